bf16_mult_arbiter: RTL and testbench
====================================

Name: bf16_mult_arbiter

Overview:
- Shares one pipelined bf16 multiplier (bfp16_mult: clk/rst/A/B/O, fixed latency) among N_REQ requesters, such as systolic-array edge feeders and the post-processing unit.
- Round-robin arbitration with a valid/ready handshake; issues at most one multiply per cycle.
- Carries a requester-ID tag alongside the multiplier pipeline and returns each product on a single tagged response port.
- Sits between the requesters and the shared multiplier instance; the multiplier itself is instantiated outside this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must satisfy ID_W = clog2(N_REQ).
- MULT_LAT, 2, register stages inside the attached multiplier, measured from an A/B change to a valid O (1..8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  issue enable; 0 stalls new grants, while in-flight operations still complete.
- req_valid  in  N_REQ  per-requester request.
- req_a  in  N_REQ*16  packed bf16 operand A; requester i occupies bits [16i+15:16i].
- req_b  in  N_REQ*16  packed bf16 operand B, same packing.
- req_ready  out  N_REQ  one-hot grant (or all-zero).
- mult_a  out  16  operand A to the multiplier.
- mult_b  out  16  operand B to the multiplier.
- mult_o  in  16  multiplier result.
- rsp_valid  out  1  response valid.
- rsp_id  out  ID_W  requester that owns rsp_data.
- rsp_data  out  16  bf16 product.
- busy  out  1  at least one operation is in flight.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - mult_a, mult_b, rsp_data = 16'h0000; rsp_valid = 0; rsp_id = 0; busy = 0.
  - Tag pipeline valids cleared; round-robin pointer = 0.
  - req_ready forced to 0 while rst=1.
- Arbitration (combinational):
  - req_ready[i] = en & ~rst & req_valid[i], for the first i found scanning upward from the pointer, modulo N_REQ.
  - At most one bit set; all zero if no requests or en=0.
- Handshake:
  - Transfer when req_valid[i] & req_ready[i] at a rising edge.
  - A requester holds req_valid and its operands stable until granted; withdrawing before a grant is legal.
  - No response backpressure: the requester must consume rsp on the cycle rsp_valid=1.
- Pointer update:
  - On a transfer for requester i, pointer <= (i+1) mod N_REQ.
  - With no transfer, pointer holds.
  - Guarantees every continuously-requesting requester is granted within N_REQ cycles.
- Issue:
  - On a transfer edge: mult_a/mult_b <= that requester's operands; tag stage 0 <= {1, i}.
  - With no transfer, mult_a/mult_b hold their last values and tag stage 0 valid <= 0.
- Tag pipeline:
  - MULT_LAT+1 stages of {valid, id}, shifting every cycle.
  - Stage MULT_LAT aligns with mult_o.
- Response:
  - rsp_valid/rsp_id <= last tag stage; rsp_data <= mult_o when that stage is valid, else hold.
  - rsp_valid goes high exactly MULT_LAT+1 rising edges after the accepting edge and lasts 1 cycle per operation.
  - Back-to-back issues yield back-to-back responses in issue order.
- Data path: results pass through unmodified; NaN, Inf, zero and denormal handling belongs to the multiplier.
- busy = OR of all tag-stage valids; it does not include rsp_valid.
- en deassert: takes effect the same cycle (no grant); the pipeline drains normally.
- Reset mid-operation: in-flight tags are discarded, so no rsp_valid pulse appears for operations accepted before reset.
- Simultaneous requests with a pointer wrap, e.g. pointer=3 and requests {0,3}: grant 3, then pointer=0, then grant 0.

Test Plan:
- Single request: req0 issues A=16'h4000 (2.0), B=16'h4040 (3.0).
  - Required: req_ready[0] same cycle; rsp_valid high 3 edges later (MULT_LAT=2) with rsp_id=0, rsp_data=16'h40C0 (6.0); busy high for 3 cycles.
- All four requesters valid continuously after reset.
  - Required: grants 0,1,2,3,0,1…, one per cycle.
  - Required: responses back-to-back with ids in the same order.
  - Operands: req1 = 16'hC000*16'hC040, which must return 16'h40C0; req2 = 16'h3FC0*16'h4000, which must return 16'h4040.
- Pointer wrap: after a grant to 2, assert req_valid={req3, req0} together.
  - Required: 3 granted first, then 0.
- en=0 with req1 valid for 5 cycles: req_ready=0 throughout and no rsp. Then raise en: req1 granted that cycle.
- Reset mid-flight: issue req2 (16'h4000*16'h0000), assert rst on the next edge.
  - Required: rsp_valid never rises; busy=0, pointer=0 after reset.
  - Required: a subsequent req3 is granted normally.
- Zero/special passthrough: req0 16'h7F80*16'h4040 → rsp_data equals the multiplier's mult_o for that pair (bench model returns 16'h7F80), rsp_id=0.

Source files
------------

// File: rtl/bf16_mult_arbiter.sv
// bf16_mult_arbiter
//   Shares one external pipelined bf16 multiplier among N_REQ requesters.
//   A round-robin arbiter grants at most one requester per cycle. The granted
//   operands are registered onto mult_a/mult_b. A {valid, id} tag travels in a
//   shift register that is matched to the multiplier latency, so each product
//   comes back on one tagged response port. Product bits are passed through
//   untouched.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   en               issue enable (0 blocks new grants; in-flight ops drain)
//   req_valid        per-requester request
//   req_a, req_b     packed bf16 operands, requester i at [16i+15:16i]
//   req_ready        one-hot grant (or all-zero)
//   mult_a, mult_b   operands to the shared multiplier
//   mult_o           multiplier result, MULT_LAT cycles after mult_a/mult_b
//   rsp_valid        one-cycle response strobe
//   rsp_id, rsp_data owning requester and bf16 product
//   busy             at least one tag stage holds a live operation
module bf16_mult_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MULT_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*16-1:0]   req_a,
  input  logic [N_REQ*16-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [15:0]           mult_a,
  output logic [15:0]           mult_b,
  input  logic [15:0]           mult_o,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_data,
  output logic                  busy
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            xfer;
  logic [ID_W:0]   scan;
  logic [ID_W-1:0] cand;

  // Tag stage s lines up with multiplier register stage s; stage MULT_LAT
  // is aligned with mult_o.
  logic [MULT_LAT:0] tag_vld_p;
  logic [ID_W-1:0]   tag_id_p [MULT_LAT+1];

  // Arbitration: the first requester at or above ptr, wrapping modulo N_REQ.
  // Only asserted requests can be granted, so a grant is always a transfer.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    xfer      = 1'b0;
    scan      = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(N_REQ)) scan = scan - (ID_W+1)'(N_REQ);
      cand = scan[ID_W-1:0];
      if (!xfer && en && !rst && req_valid[cand]) begin
        xfer   = 1'b1;
        gnt_id = cand;
      end
    end
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  // Issue stage (p0): operands to the multiplier, tag enters stage 0
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
      tag_vld_p <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (xfer) begin
        ptr    <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
        mult_a <= req_a[16*int'(gnt_id) +: 16];
        mult_b <= req_b[16*int'(gnt_id) +: 16];
      end
      tag_vld_p <= {tag_vld_p[MULT_LAT-1:0], xfer};
      // Response stage: capture the product when the aligned tag is live
      rsp_valid <= tag_vld_p[MULT_LAT];
      rsp_id    <= tag_id_p[MULT_LAT];
      if (tag_vld_p[MULT_LAT]) rsp_data <= mult_o;
    end
  end

  // Tag ids are only meaningful next to a set valid bit, so they are not reset.
  always_ff @(posedge clk) begin
    tag_id_p[0] <= gnt_id;
    for (int s = 1; s <= MULT_LAT; s++) tag_id_p[s] <= tag_id_p[s-1];
  end

  assign busy = |tag_vld_p;

endmodule

// File: tb/tb_bf16_mult_arbiter.sv
module tb_bf16_mult_arbiter;
  localparam int N_REQ    = 4;
  localparam int ID_W     = 2;
  localparam int MULT_LAT = 2;

  logic                clk = 1'b0;
  logic                rst, en;
  logic [N_REQ-1:0]    req_valid, req_ready;
  logic [N_REQ*16-1:0] req_a, req_b;
  logic [15:0]         mult_a, mult_b, mult_o, rsp_data;
  logic                rsp_valid, busy;
  logic [ID_W-1:0]     rsp_id;

  always #5 clk = ~clk;

  bf16_mult_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .mult_a(mult_a), .mult_b(mult_b),
    .mult_o(mult_o), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Behavioural bf16 multiply: RNE, denormals flushed, canonical NaN.
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic s; int ea, eb, e; logic [15:0] p; logic [7:0] keep, rest; logic [8:0] m; logic rnd;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if ((ea == 255 && a[6:0] != 0) || (eb == 255 && b[6:0] != 0)) return 16'h7FC0;
    if (ea == 255 || eb == 255) begin
      if (ea == 0 || eb == 0) return 16'h7FC0;
      return {s, 8'hFF, 7'h00};
    end
    if (ea == 0 || eb == 0) return {s, 15'h0};
    p = {8'h0, 1'b1, a[6:0]} * {8'h0, 1'b1, b[6:0]};
    e = ea + eb - 127;
    if (p[15]) begin e++; keep = p[15:8]; rest = p[7:0]; end
    else begin keep = p[14:7]; rest = {p[6:0], 1'b0}; end
    rnd = rest[7] && ((rest[6:0] != 0) || keep[0]);
    m = {1'b0, keep} + {8'h0, rnd};
    if (m[8]) begin m = m >> 1; e++; end
    if (e >= 255) return {s, 8'hFF, 7'h00};
    if (e <= 0) return {s, 15'h0};
    return {s, e[7:0], m[6:0]};
  endfunction

  // External multiplier stand-in: MULT_LAT register stages.
  logic [15:0] mpipe [MULT_LAT];
  always @(posedge clk) begin
    mpipe[0] <= bf16_mul(mult_a, mult_b);
    for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mult_o = mpipe[MULT_LAT-1];

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle-time %0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted operation with the edge index it was issued on.
  typedef struct { int id; logic [15:0] a; logic [15:0] b; logic [15:0] p; int e; } op_t;
  op_t q[$];
  int  cyc = 0, mptr = 0;
  bit  hold = 0;
  logic [N_REQ-1:0] granted = '0;
  int  gnt_log[$];
  int  rsp_ids[$];
  logic [15:0] rsp_datas[$];
  int  dut_rsp_cnt = 0, busy_cnt = 0, last_rsp_cyc = 0, last_gnt_cyc = 0, last_id = 0;
  logic [15:0] last_data = '0;

  function automatic int model_grant();
    int i;
    if (!en || rst) return -1;
    for (int k = 0; k < N_REQ; k++) begin
      i = (mptr + k) % N_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic observe();
    int g; logic [N_REQ-1:0] er; bit rv, bz; op_t hit, n;
    g = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    rv = 0; bz = 0; hit = '{0, 16'h0, 16'h0, 16'h0, 0};
    foreach (q[j]) begin
      if (q[j].e + MULT_LAT + 1 == cyc) begin rv = 1; hit = q[j]; end
      if (q[j].e <= cyc && cyc <= q[j].e + MULT_LAT) bz = 1;
      if (q[j].e == cyc) begin
        chk("mult_a", 32'(mult_a), 32'(q[j].a));
        chk("mult_b", 32'(mult_b), 32'(q[j].b));
      end
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(rv));
    chk("busy", 32'(busy), 32'(bz));
    if (rv) begin
      chk("rsp_id", 32'(rsp_id), 32'(hit.id));
      chk("rsp_data", 32'(rsp_data), 32'(hit.p));
    end
    if (rsp_valid) begin
      dut_rsp_cnt++; last_rsp_cyc = cyc; last_data = rsp_data; last_id = int'(rsp_id);
      rsp_ids.push_back(int'(rsp_id)); rsp_datas.push_back(rsp_data);
    end
    if (busy) busy_cnt++;
    granted = '0;
    if (rst) begin
      q.delete();
      mptr = 0;
    end else begin
      while (q.size() > 0 && q[0].e + MULT_LAT + 1 <= cyc) void'(q.pop_front());
      if (g >= 0) begin
        n.id = g; n.a = req_a[16*g +: 16]; n.b = req_b[16*g +: 16];
        n.p = bf16_mul(n.a, n.b); n.e = cyc + 1;
        q.push_back(n);
        mptr = (g + 1) % N_REQ;
        granted[g] = 1'b1;
        gnt_log.push_back(g);
        last_gnt_cyc = cyc + 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
    if (!hold) req_valid = req_valid & ~granted;
  endtask

  task automatic put(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i] = 1'b1;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  int snap, b0, n;

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    // Requests during reset must not be granted
    en = 1'b1; put(0, 16'h4000, 16'h4040);
    cycle();
    rst = 1'b0; req_valid = '0;
    chk("rst_mult_a", 32'(mult_a), 32'h0);
    chk("rst_mult_b", 32'(mult_b), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single request 2.0 * 3.0
    b0 = busy_cnt;
    put(0, 16'h4000, 16'h4040);
    cycle();
    chk("t1_grant", 32'(gnt_log[gnt_log.size()-1]), 32'd0);
    repeat (6) cycle();
    chk("t1_data", 32'(last_data), 32'h40C0);
    chk("t1_id", 32'(last_id), 32'd0);
    chk("t1_latency", 32'(last_rsp_cyc - last_gnt_cyc), 32'(MULT_LAT + 1));
    chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd3);

    // All four continuously valid right after reset
    rst = 1'b1; cycle(); rst = 1'b0;
    gnt_log.delete(); rsp_ids.delete(); rsp_datas.delete();
    hold = 1;
    put(0, 16'h4000, 16'h4040); put(1, 16'hC000, 16'hC040);
    put(2, 16'h3FC0, 16'h4000); put(3, 16'h3F80, 16'h3F80);
    repeat (12) cycle();
    hold = 0; req_valid = '0;
    repeat (5) cycle();
    for (int k = 0; k < 8; k++) begin
      chk("t2_grant_order", 32'(gnt_log[k]), 32'(k % 4));
      chk("t2_rsp_order", 32'(rsp_ids[k]), 32'(k % 4));
    end
    chk("t2_rsp0", 32'(rsp_datas[0]), 32'h40C0);
    chk("t2_rsp1", 32'(rsp_datas[1]), 32'h40C0);
    chk("t2_rsp2", 32'(rsp_datas[2]), 32'h4040);
    chk("t2_rsp3", 32'(rsp_datas[3]), 32'h3F80);

    // Pointer wrap: grant 2, then {3,0} together
    put(2, 16'h4000, 16'h4000);
    cycle();
    put(3, 16'h4040, 16'h4000); put(0, 16'h4000, 16'h4040);
    cycle(); cycle();
    n = gnt_log.size();
    chk("t3_first", 32'(gnt_log[n-2]), 32'd3);
    chk("t3_second", 32'(gnt_log[n-1]), 32'd0);
    repeat (5) cycle();

    // en low stalls grants
    en = 1'b0; snap = dut_rsp_cnt; n = gnt_log.size();
    put(1, 16'h4000, 16'h4000);
    repeat (5) cycle();
    chk("t4_no_grant", 32'(gnt_log.size()), 32'(n));
    chk("t4_no_rsp", 32'(dut_rsp_cnt), 32'(snap));
    en = 1'b1;
    cycle();
    chk("t4_grant", 32'(gnt_log[gnt_log.size()-1]), 32'd1);
    repeat (5) cycle();

    // Reset with an operation in flight
    put(2, 16'h4000, 16'h0000);
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'h0);
    snap = dut_rsp_cnt;
    put(1, 16'h4000, 16'h4000); put(3, 16'h4040, 16'h4040);
    cycle(); cycle();
    n = gnt_log.size();
    chk("t5_ptr0_first", 32'(gnt_log[n-2]), 32'd1);
    chk("t5_req3", 32'(gnt_log[n-1]), 32'd3);
    repeat (6) cycle();
    chk("t5_rsp_count", 32'(dut_rsp_cnt), 32'(snap + 2));

    // Special value passes through
    put(0, 16'h7F80, 16'h4040);
    cycle();
    repeat (5) cycle();
    chk("t6_inf", 32'(last_data), 32'h7F80);
    chk("t6_id", 32'(last_id), 32'd0);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      en  = ($urandom_range(0, 99) < 85);
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 99) < 40) put(i, 16'($urandom), 16'($urandom));
        end else if ($urandom_range(0, 99) < 5) begin
          req_valid[i] = 1'b0;
        end
      end
      cycle();
    end
    rst = 1'b0; req_valid = '0;
    repeat (6) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
